// File: rtl/murax_reset_sequencer.sv
// Reset sequencer for the Murax SoC. It qualifies PLL lock and then releases debug_reset before sys_reset.
// Define RESET_SEQ_BUTTON_EN to build the debounced push-button path that re-asserts the system reset.
module murax_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES     = 1024,
  parameter int unsigned HOLD_CYCLES            = 64,
  parameter int unsigned SYS_DELAY_CYCLES       = 16,
  parameter int unsigned BUTTON_DEBOUNCE_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       button_n,
  output logic       debug_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] lock_lost_count
);

  localparam int unsigned MAX_LH  = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_LH > SYS_DELAY_CYCLES) ? MAX_LH : SYS_DELAY_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(SYS_DELAY_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STABLE,
    ST_DBG_HOLD,
    ST_SYS_HOLD,
    ST_RUN
  } state_t;

  logic lock_meta_q;
  logic lock_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  logic button_pressed;

`ifdef RESET_SEQ_BUTTON_EN
  localparam int unsigned DB_W = (BUTTON_DEBOUNCE_CYCLES > 1) ? $clog2(BUTTON_DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(BUTTON_DEBOUNCE_CYCLES - 1);

  logic            btn_meta_q;
  logic            btn_s_q;
  logic            btn_db_q;
  logic            btn_db_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;

  // The run counter restarts whenever the synchronized level agrees with the accepted level.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_q <= 1'b1;
      btn_s_q    <= 1'b1;
      btn_db_q   <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      btn_meta_q <= button_n;
      btn_s_q    <= btn_meta_q;
      btn_db_q   <= btn_db_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign button_pressed = ~btn_db_q;
`else
  localparam int unsigned unused_debounce_cycles = BUTTON_DEBOUNCE_CYCLES;
  logic unused_button;
  assign unused_button  = button_n;
  assign button_pressed = 1'b0;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       lost_q;
  logic [7:0]       lost_d;
  logic             debug_reset_q;
  logic             debug_reset_d;
  logic             sys_reset_q;
  logic             sys_reset_d;
  logic             ready_q;
  logic             ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (lock_s_q) begin
          state_d = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (cnt_q == LOCK_LAST) begin
          state_d = ST_DBG_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DBG_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_SYS_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SYS_HOLD: begin
        if (button_pressed) begin
          cnt_d = '0;
        end else if (cnt_q == SYS_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (button_pressed) begin
          state_d = ST_SYS_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Lock loss overrides every other transition, including a counter expiring this cycle.
    if ((state_q != ST_IDLE) && !lock_s_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      if ((state_q == ST_RUN) && (lost_q != 8'hFF)) begin
        lost_d = lost_q + 8'd1;
      end
    end

    debug_reset_d = (state_d == ST_IDLE) || (state_d == ST_STABLE) || (state_d == ST_DBG_HOLD);
    sys_reset_d   = (state_d != ST_RUN);
    ready_d       = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lost_q        <= 8'd0;
      debug_reset_q <= 1'b1;
      sys_reset_q   <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lost_q        <= lost_d;
      debug_reset_q <= debug_reset_d;
      sys_reset_q   <= sys_reset_d;
      ready_q       <= ready_d;
    end
  end

  assign debug_reset     = debug_reset_q;
  assign sys_reset       = sys_reset_q;
  assign ready           = ready_q;
  assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_murax_reset_sequencer.sv
// Testbench for murax_reset_sequencer: a cycle-count reference model checked every cycle, plus literal timing checks.
// The button scenarios run only when RESET_SEQ_BUTTON_EN is defined.
module tb_murax_reset_sequencer;

  localparam int L = 8;
  localparam int H = 4;
  localparam int S = 2;
  localparam int N = 5;
  localparam int DBG_END = 1 + L + H;
`ifdef RESET_SEQ_BUTTON_EN
  localparam bit BTN_EN = 1'b1;
`else
  localparam bit BTN_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       button_n;
  logic       debug_reset;
  logic       sys_reset;
  logic       ready;
  logic [7:0] lock_lost_count;

  murax_reset_sequencer #(
    .LOCK_STABLE_CYCLES    (L),
    .HOLD_CYCLES           (H),
    .SYS_DELAY_CYCLES      (S),
    .BUTTON_DEBOUNCE_CYCLES(N)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_lock       (pll_lock),
    .button_n       (button_n),
    .debug_reset    (debug_reset),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .lock_lost_count(lock_lost_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model. r counts consecutive edges on which the FSM saw lock high;
  // k counts edges in the system-release phase since the last debounced press.
  int m_r, m_k, m_cnt, m_run;
  bit m_s1, m_s2, m_b1, m_b2, m_db, m_val;
  bit exp_dbg, exp_sys, exp_rdy;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_s1 = 0; m_s2 = 0; m_r = 0; m_k = 0; m_cnt = 0;
        m_b1 = 1; m_b2 = 1; m_db = 1; m_val = 1; m_run = 0;
      end else begin
        bit seen, db_old, was_run;
        seen    = m_s2;
        db_old  = m_db;
        was_run = (m_r > DBG_END) && (m_k >= S);
        if (!seen) begin
          if (was_run && m_cnt < 255) m_cnt++;
          m_r = 0;
          m_k = 0;
        end else begin
          m_r++;
          if (m_r == DBG_END) m_k = 0;
          else if (m_r > DBG_END) m_k = (BTN_EN && !db_old) ? 0 : m_k + 1;
        end
        if (m_b2 == m_val) m_run++;
        else begin
          m_val = m_b2;
          m_run = 1;
        end
        if (m_val != m_db && m_run >= N) m_db = m_val;
        m_s2 = m_s1; m_s1 = pll_lock;
        m_b2 = m_b1; m_b1 = button_n;
      end
      exp_dbg = (m_r < DBG_END);
      exp_sys = !((m_r >= DBG_END) && (m_k >= S));
      exp_rdy = !exp_sys;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("model_debug_reset", {31'd0, debug_reset}, {31'd0, exp_dbg});
      check("model_sys_reset", {31'd0, sys_reset}, {31'd0, exp_sys});
      check("model_ready", {31'd0, ready}, {31'd0, exp_rdy});
      check("model_lock_lost_count", {24'd0, lock_lost_count}, m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input bit d, input bit s, input bit r);
    check({name, "_debug_reset"}, {31'd0, debug_reset}, {31'd0, d});
    check({name, "_sys_reset"}, {31'd0, sys_reset}, {31'd0, s});
    check({name, "_ready"}, {31'd0, ready}, {31'd0, r});
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int press_left;
    reset = 1'b1; pll_lock = 1'b0; button_n = 1'b1;

    // Power-up
    repeat (3) begin
      tick(1);
      expect_out("powerup_reset", 1, 1, 0);
      check("powerup_count", {24'd0, lock_lost_count}, 0);
    end
    reset = 1'b0;
    tick(5);
    expect_out("powerup_nolock", 1, 1, 0);

    // Clean lock: pll_lock rises before E0
    pll_lock = 1'b1;
    tick(14); expect_out("clean_e13", 1, 1, 0);
    tick(1);  expect_out("clean_e14", 0, 1, 0);
    tick(1);  expect_out("clean_e15", 0, 1, 0);
    tick(1);  expect_out("clean_e16", 0, 0, 1);

    // Loss in RUN
    tick(3);
    pll_lock = 1'b0;
    tick(2); expect_out("loss_k1", 0, 0, 1);
    tick(1); expect_out("loss_k2", 1, 1, 0);
    check("loss_count", {24'd0, lock_lost_count}, 1);

    // One-cycle glitch while qualifying
    tick(2);
    pll_lock = 1'b1;
    tick(4);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(14); expect_out("glitch_e18", 1, 1, 0);
    tick(1);  expect_out("glitch_e19", 0, 1, 0);
    tick(2);  expect_out("glitch_e21", 0, 0, 1);

`ifdef RESET_SEQ_BUTTON_EN
    // Short press is filtered
    button_n = 1'b0;
    tick(3);
    button_n = 1'b1;
    tick(8);
    expect_out("btn_short", 0, 0, 1);

    // Long press
    button_n = 1'b0;
    tick(7); expect_out("btn_long_p6", 0, 0, 1);
    tick(1); expect_out("btn_long_p7", 0, 1, 0);
    tick(2);
    button_n = 1'b1;
    tick(8); expect_out("btn_long_p17", 0, 1, 0);
    tick(1); expect_out("btn_long_p18", 0, 0, 1);
`endif

    // Reset mid-sequence from DBG_HOLD
    pll_lock = 1'b0;
    tick(4);
    pll_lock = 1'b1;
    tick(12);
    expect_out("midrst_before", 1, 1, 0);
    reset = 1'b1;
    tick(1);
    expect_out("midrst_after", 1, 1, 0);
    check("midrst_count", {24'd0, lock_lost_count}, 0);
    reset = 1'b0;
    tick(14); expect_out("midrst_r13", 1, 1, 0);
    tick(1);  expect_out("midrst_r14", 0, 1, 0);
    tick(2);  expect_out("midrst_r16", 0, 0, 1);

    // Saturation of the loss counter
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      wait_ready(40);
      pll_lock = 1'b0;
      tick(4);
    end
    check("saturate_count", {24'd0, lock_lost_count}, 255);

    // Randomized traffic
    press_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (pll_lock) begin
        if ($urandom_range(79, 0) == 0) pll_lock = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        pll_lock = 1'b1;
      end
      if (press_left > 0) begin
        press_left--;
        if (press_left == 0) button_n = 1'b1;
      end else if ($urandom_range(39, 0) == 0) begin
        press_left = $urandom_range(12, 1);
        button_n = 1'b0;
      end
      reset = ($urandom_range(399, 0) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
